// File: rtl/twiddle_mult.sv
// Twiddle-multiplication stage between radix-2^2 SDF butterfly pairs: addresses the twiddle ROM,
// aligns samples with its registered output, and does a rounded, saturating complex multiply.
module twiddle_mult #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned TW_WIDTH = 8,
    parameter int unsigned LOG_N    = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       din_valid,
    input  logic signed [WIDTH-1:0]    din_re,
    input  logic signed [WIDTH-1:0]    din_im,
    output logic        [LOG_N-1:0]    tw_addr,
    input  logic signed [TW_WIDTH-1:0] tw_re,
    input  logic signed [TW_WIDTH-1:0] tw_im,
    output logic                       dout_valid,
    output logic signed [WIDTH-1:0]    dout_re,
    output logic signed [WIDTH-1:0]    dout_im,
    output logic                       dout_sof
);

    localparam int unsigned PW    = WIDTH + TW_WIDTH;
    localparam int unsigned SW    = PW + 1;
    localparam int unsigned Shift = TW_WIDTH - 2;

    localparam logic signed [SW-1:0] Rnd  = SW'(2 ** (TW_WIDTH - 3));
    localparam logic signed [SW-1:0] MaxV = SW'(2 ** (WIDTH - 1) - 1);
    localparam logic signed [SW-1:0] MinV = ~MaxV;

    logic        [LOG_N-1:0] cnt_q, cnt_d;
    logic signed [WIDTH-1:0] s0_re_q, s0_re_d, s0_im_q, s0_im_d;
    logic                    s0_vld_q, s0_vld_d, s0_sof_q, s0_sof_d;
    logic signed [PW-1:0]    s1_rr_q, s1_rr_d, s1_ii_q, s1_ii_d;
    logic signed [PW-1:0]    s1_ri_q, s1_ri_d, s1_ir_q, s1_ir_d;
    logic                    s1_vld_q, s1_vld_d, s1_sof_q, s1_sof_d;
    logic signed [WIDTH-1:0] dout_re_q, dout_re_d, dout_im_q, dout_im_d;
    logic                    dout_vld_q, dout_vld_d, dout_sof_q, dout_sof_d;
    logic signed [SW-1:0]    re_sum, im_sum, re_shf, im_shf;

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [SW-1:0] v);
        if (v > MaxV) begin
            return {1'b0, {(WIDTH - 1){1'b1}}};
        end else if (v < MinV) begin
            return {1'b1, {(WIDTH - 1){1'b0}}};
        end
        return v[WIDTH-1:0];
    endfunction

    always_comb begin
        cnt_d    = din_valid ? cnt_q + 1'b1 : cnt_q;
        s0_re_d  = din_re;
        s0_im_d  = din_im;
        s0_vld_d = din_valid;
        s0_sof_d = din_valid && (cnt_q == '0);

        // tw_re/tw_im belong to the sample held in stage 0 (ROM has one cycle of latency)
        s1_rr_d  = PW'(s0_re_q) * PW'(tw_re);
        s1_ii_d  = PW'(s0_im_q) * PW'(tw_im);
        s1_ri_d  = PW'(s0_re_q) * PW'(tw_im);
        s1_ir_d  = PW'(s0_im_q) * PW'(tw_re);
        s1_vld_d = s0_vld_q;
        s1_sof_d = s0_sof_q;

        re_sum = SW'(s1_rr_q) - SW'(s1_ii_q);
        im_sum = SW'(s1_ri_q) + SW'(s1_ir_q);
        re_shf = (re_sum + Rnd) >>> Shift;
        im_shf = (im_sum + Rnd) >>> Shift;

        dout_re_d  = s1_vld_q ? sat(re_shf) : dout_re_q;
        dout_im_d  = s1_vld_q ? sat(im_shf) : dout_im_q;
        dout_vld_d = s1_vld_q;
        dout_sof_d = s1_vld_q && s1_sof_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            s0_re_q    <= '0;
            s0_im_q    <= '0;
            s0_vld_q   <= 1'b0;
            s0_sof_q   <= 1'b0;
            s1_rr_q    <= '0;
            s1_ii_q    <= '0;
            s1_ri_q    <= '0;
            s1_ir_q    <= '0;
            s1_vld_q   <= 1'b0;
            s1_sof_q   <= 1'b0;
            dout_re_q  <= '0;
            dout_im_q  <= '0;
            dout_vld_q <= 1'b0;
            dout_sof_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            s0_re_q    <= s0_re_d;
            s0_im_q    <= s0_im_d;
            s0_vld_q   <= s0_vld_d;
            s0_sof_q   <= s0_sof_d;
            s1_rr_q    <= s1_rr_d;
            s1_ii_q    <= s1_ii_d;
            s1_ri_q    <= s1_ri_d;
            s1_ir_q    <= s1_ir_d;
            s1_vld_q   <= s1_vld_d;
            s1_sof_q   <= s1_sof_d;
            dout_re_q  <= dout_re_d;
            dout_im_q  <= dout_im_d;
            dout_vld_q <= dout_vld_d;
            dout_sof_q <= dout_sof_d;
        end
    end

    assign tw_addr    = cnt_q;
    assign dout_valid = dout_vld_q;
    assign dout_re    = dout_re_q;
    assign dout_im    = dout_im_q;
    assign dout_sof   = dout_sof_q;

endmodule
